draw_brick_rect_gen: RTL
========================

// Module: draw_brick_rect_gen
// PURPOSE
//  Reverse of the pixel->brick field lookup: takes one brick coordinate (col,row) plus colour
//  and emits, in raster order, every screen pixel that brick covers, with a valid/ready stream.
//  Sits between the game-field update logic and the framebuffer writer. Repaints changed bricks
//  only, so no full-frame redraw is needed. Geometry matches the field draw path exactly.
// PARAMETERS
//  PIX_WIDTH    12  width of pixel x/y coordinates
//  BRICK_X      20  brick width, pixels
//  BRICK_Y      25  brick height, pixels
//  BRICK_X_CNT  10  bricks per row
//  BRICK_Y_CNT  20  bricks per column
//  BORDER_X     2   gap before each brick column and after the last, pixels
//  BORDER_Y     2   gap before each brick row and after the last, pixels
//  COLOR_W      4   colour index width
// PORTS
//  clk            in   1                  system clock
//  rst_n_i        in   1                  async active-low reset
//  start_x_i      in   PIX_WIDTH          field origin x; quasi-static
//  start_y_i      in   PIX_WIDTH          field origin y; quasi-static
//  req_valid_i    in   1                  brick draw request valid
//  req_ready_o    out  1                  request accepted when valid&&ready
//  brick_col_i    in   $clog2(BRICK_X_CNT) brick column
//  brick_row_i    in   $clog2(BRICK_Y_CNT) brick row
//  brick_color_i  in   COLOR_W            brick colour
//  pix_valid_o    out  1                  pixel beat valid
//  pix_ready_i    in   1                  downstream accepts beat
//  pix_x_o        out  PIX_WIDTH          pixel x, absolute screen coordinate
//  pix_y_o        out  PIX_WIDTH          pixel y, absolute screen coordinate
//  pix_color_o    out  COLOR_W            colour latched at request accept
//  pix_last_o     out  1                  marks last beat of brick (bottom-right pixel)
//  busy_o         out  1                  high in any state other than IDLE
//  err_o          out  1                  1-cycle pulse: col/row out of range
// BEHAVIOUR
//  Reset: state=IDLE; req_ready_o=1; pix_valid_o, pix_last_o, busy_o and err_o = 0.
//   pix_x_o, pix_y_o and pix_color_o = 0. Reset mid-run aborts the brick; no beats are
//   emitted after reset is released.
//  FSM IDLE->CALC->RUN->IDLE.
//  IDLE: req_ready_o=1. On valid&&ready, latch col, row and colour, then go to CALC.
//  CALC (1 cycle):
//   - If col>=BRICK_X_CNT or row>=BRICK_Y_CNT, pulse err_o and go to IDLE; no beats.
//   - Otherwise:
//     org_x = start_x + (col+1)*BORDER_X + col*BRICK_X
//     org_y = start_y + (row+1)*BORDER_Y + row*BRICK_Y
//   - Arithmetic is in PIX_WIDTH, modulo 2^PIX_WIDTH; there is no overflow detection.
//  RUN: emit BRICK_X*BRICK_Y beats, x fastest. The first beat is (org_x,org_y); the last
//   beat is (org_x+BRICK_X-1, org_y+BRICK_Y-1).
//   - Beat is consumed on pix_valid_o && pix_ready_i.
//   - Counters x_cnt/y_cnt advance only on a consumed beat.
//   - While pix_ready_i=0, all pix_* outputs hold stable (AXI-stream style).
//   - pix_valid_o never drops without a handshake.
//   - x wraps to 0 with y+1 at x_cnt==BRICK_X-1.
//   - The consumed beat with pix_last_o=1 returns the FSM to IDLE.
//  Latency: request accepted at cycle N -> first pix_valid_o at N+2.
//  req_ready_o rises in the cycle after the last handshake. Minimum inter-brick gap is
//   2 cycles (IDLE + CALC).
//  req_ready_o is 0 outside IDLE; requests there are not accepted and req_valid_i is
//   ignored.
//  start_x_i/start_y_i are sampled only in CALC; changes during RUN do not affect the
//   current brick.
//  pix_* outputs are registered. pix_x_o/pix_y_o/pix_color_o keep their last values in
//   IDLE; only pix_valid_o qualifies them.
// STRUCTURE
//  Shared package draw_field_pkg:
//   - geometry localparams: brick pitch (BRICK_X+BORDER_X, BRICK_Y+BORDER_Y) and field
//     end offsets
//   - typedef brick_col_t/brick_row_t
//   - state enum draw_brick_state_t {IDLE,CALC,RUN}
//  One sub-module brick_origin_calc (combinational col/row -> pixel offset).
//   - The field-draw path will reuse it, so both directions share one geometry formula.
//  Top holds the FSM, latches, x/y counters and output register stage.
// TESTING
//  Defaults, start=(100,50):
//   1. col=0,row=0,colour=5, pix_ready_i=1 -> 500 beats; first (102,52), last (121,76)
//      with pix_last_o=1; beat 21 is (102,53).
//   2. col=9,row=19 -> first (300,565), last (319,589); never reaches field border
//      columns 320-321 or rows 590-591.
//   3. Backpressure: pix_ready_i low for 3 cycles at beat 40 -> pix_x/y/colour stable;
//      total handshakes still 500.
//   4. col=10 (or row=20) -> err_o pulses 1 cycle at N+1; no pix_valid_o;
//      req_ready_o=1 at N+2.
//   5. Back-to-back requests with req_valid_i held high -> second brick's first beat
//      comes 3 cycles after the first brick's last handshake; colours do not mix.
//   6. rst_n_i asserted mid-RUN (beat 200) -> outputs go to reset values immediately;
//      after release, IDLE with req_ready_o=1 and no stray beats.

Source files
------------

// File: rtl/draw_brick_rect_gen_pkg.sv
// Shared brick-field geometry and types, used by both the field draw path and
// the single-brick rectangle generator.
package draw_field_pkg;

  localparam int DEF_PIX_WIDTH   = 12;
  localparam int DEF_BRICK_X     = 20;
  localparam int DEF_BRICK_Y     = 25;
  localparam int DEF_BRICK_X_CNT = 10;
  localparam int DEF_BRICK_Y_CNT = 20;
  localparam int DEF_BORDER_X    = 2;
  localparam int DEF_BORDER_Y    = 2;
  localparam int DEF_COLOR_W     = 4;

  localparam int BRICK_PITCH_X = DEF_BRICK_X + DEF_BORDER_X;
  localparam int BRICK_PITCH_Y = DEF_BRICK_Y + DEF_BORDER_Y;

  // Offset of the first pixel past the trailing border, relative to the field origin
  localparam int FIELD_END_X = DEF_BRICK_X_CNT * BRICK_PITCH_X + DEF_BORDER_X;
  localparam int FIELD_END_Y = DEF_BRICK_Y_CNT * BRICK_PITCH_Y + DEF_BORDER_Y;

  localparam int BRICK_COL_W = $clog2(DEF_BRICK_X_CNT);
  localparam int BRICK_ROW_W = $clog2(DEF_BRICK_Y_CNT);

  typedef logic [BRICK_COL_W-1:0] brick_col_t;
  typedef logic [BRICK_ROW_W-1:0] brick_row_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RUN
  } draw_brick_state_t;

endpackage

// File: rtl/draw_brick_rect_gen_origin_calc.sv
// Combinational brick (col,row) -> pixel offset from the field origin.
// Out-of-range coordinates still produce an offset; in_range qualifies it.
module brick_origin_calc #(
  parameter int PIX_WIDTH   = draw_field_pkg::DEF_PIX_WIDTH,
  parameter int BRICK_X     = draw_field_pkg::DEF_BRICK_X,
  parameter int BRICK_Y     = draw_field_pkg::DEF_BRICK_Y,
  parameter int BRICK_X_CNT = draw_field_pkg::DEF_BRICK_X_CNT,
  parameter int BRICK_Y_CNT = draw_field_pkg::DEF_BRICK_Y_CNT,
  parameter int BORDER_X    = draw_field_pkg::DEF_BORDER_X,
  parameter int BORDER_Y    = draw_field_pkg::DEF_BORDER_Y
) (
  input  logic [$clog2(BRICK_X_CNT)-1:0] col,
  input  logic [$clog2(BRICK_Y_CNT)-1:0] row,
  output logic [PIX_WIDTH-1:0]           off_x,
  output logic [PIX_WIDTH-1:0]           off_y,
  output logic                           in_range
);

  // (col+1)*border + col*brick folded into border + col*pitch
  assign off_x = PIX_WIDTH'(BORDER_X) + PIX_WIDTH'(col) * PIX_WIDTH'(BRICK_X + BORDER_X);
  assign off_y = PIX_WIDTH'(BORDER_Y) + PIX_WIDTH'(row) * PIX_WIDTH'(BRICK_Y + BORDER_Y);

  assign in_range = (int'(col) < BRICK_X_CNT) && (int'(row) < BRICK_Y_CNT);

endmodule

// File: rtl/draw_brick_rect_gen.sv
// Expands one brick request into a raster-ordered valid/ready stream of the
// screen pixels it covers, so single bricks can be repainted without a full redraw.
module draw_brick_rect_gen
  import draw_field_pkg::*;
#(
  parameter int PIX_WIDTH   = DEF_PIX_WIDTH,
  parameter int BRICK_X     = DEF_BRICK_X,
  parameter int BRICK_Y     = DEF_BRICK_Y,
  parameter int BRICK_X_CNT = DEF_BRICK_X_CNT,
  parameter int BRICK_Y_CNT = DEF_BRICK_Y_CNT,
  parameter int BORDER_X    = DEF_BORDER_X,
  parameter int BORDER_Y    = DEF_BORDER_Y,
  parameter int COLOR_W     = DEF_COLOR_W
) (
  input  logic                           clk,
  input  logic                           rst_n_i,
  input  logic [PIX_WIDTH-1:0]           start_x_i,
  input  logic [PIX_WIDTH-1:0]           start_y_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [$clog2(BRICK_X_CNT)-1:0] brick_col_i,
  input  logic [$clog2(BRICK_Y_CNT)-1:0] brick_row_i,
  input  logic [COLOR_W-1:0]             brick_color_i,
  output logic                           pix_valid_o,
  input  logic                           pix_ready_i,
  output logic [PIX_WIDTH-1:0]           pix_x_o,
  output logic [PIX_WIDTH-1:0]           pix_y_o,
  output logic [COLOR_W-1:0]             pix_color_o,
  output logic                           pix_last_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int COL_W = $clog2(BRICK_X_CNT);
  localparam int ROW_W = $clog2(BRICK_Y_CNT);
  localparam int XW    = $clog2(BRICK_X);
  localparam int YW    = $clog2(BRICK_Y);

  draw_brick_state_t state, next_state;

  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [COLOR_W-1:0]   color_q;
  logic [PIX_WIDTH-1:0] org_x_q, org_y_q;
  logic [PIX_WIDTH-1:0] off_x, off_y;
  logic                 in_range;
  logic [XW-1:0]        x_cnt, x_nxt;
  logic [YW-1:0]        y_cnt, y_nxt;
  logic                 x_wrap, last_nxt, beat_take;

  brick_origin_calc #(
    .PIX_WIDTH  (PIX_WIDTH),
    .BRICK_X    (BRICK_X),
    .BRICK_Y    (BRICK_Y),
    .BRICK_X_CNT(BRICK_X_CNT),
    .BRICK_Y_CNT(BRICK_Y_CNT),
    .BORDER_X   (BORDER_X),
    .BORDER_Y   (BORDER_Y)
  ) u_origin (
    .col     (col_q),
    .row     (row_q),
    .off_x   (off_x),
    .off_y   (off_y),
    .in_range(in_range)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    req_ready_o = 1'b0;
    err_o       = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) next_state = CALC;
      end
      CALC: begin
        if (!in_range) begin
          err_o      = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (beat_take && pix_last_o) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Raster walk: x fastest, wrapping into the next row at the brick's right edge
  always_comb begin
    beat_take = pix_valid_o && pix_ready_i;
    x_wrap    = (x_cnt == XW'(BRICK_X - 1));
    x_nxt     = x_wrap ? '0 : x_cnt + 1'b1;
    y_nxt     = x_wrap ? y_cnt + 1'b1 : y_cnt;
    last_nxt  = (x_nxt == XW'(BRICK_X - 1)) && (y_nxt == YW'(BRICK_Y - 1));
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_q       <= '0;
      row_q       <= '0;
      color_q     <= '0;
      org_x_q     <= '0;
      org_y_q     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      pix_valid_o <= 1'b0;
      pix_last_o  <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      pix_color_o <= '0;
    end else begin
      if (req_valid_i && req_ready_o) begin
        col_q   <= brick_col_i;
        row_q   <= brick_row_i;
        color_q <= brick_color_i;
      end
      // Field origin is sampled here only, so it may move while a brick is streaming
      if (state == CALC && in_range) begin
        org_x_q     <= start_x_i + off_x;
        org_y_q     <= start_y_i + off_y;
        pix_x_o     <= start_x_i + off_x;
        pix_y_o     <= start_y_i + off_y;
        pix_color_o <= color_q;
        pix_valid_o <= 1'b1;
        pix_last_o  <= (BRICK_X == 1) && (BRICK_Y == 1);
        x_cnt       <= '0;
        y_cnt       <= '0;
      end else if (state == RUN && beat_take) begin
        if (pix_last_o) begin
          pix_valid_o <= 1'b0;
          pix_last_o  <= 1'b0;
        end else begin
          x_cnt      <= x_nxt;
          y_cnt      <= y_nxt;
          pix_x_o    <= org_x_q + PIX_WIDTH'(x_nxt);
          pix_y_o    <= org_y_q + PIX_WIDTH'(y_nxt);
          pix_last_o <= last_nxt;
        end
      end
    end
  end

endmodule
